// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default bit timing
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uartState_t;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - free-running bit-period counter with end/near-end strobes
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Clear,
  output logic o_BitEnd,
  output logic o_BitNear
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] r_Cnt;

  // Wraps exactly at CLKS_PER_BIT-1 so every bit is the same length (no drift).
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Cnt <= '0;
    end else if (i_Clear || (r_Cnt == CW'(CLKS_PER_BIT - 1))) begin
      r_Cnt <= '0;
    end else begin
      r_Cnt <= r_Cnt + 1'b1;
    end
  end

  assign o_BitEnd  = (r_Cnt == CW'(CLKS_PER_BIT - 1));
  assign o_BitNear = (r_Cnt == CW'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains an FWFT FIFO into back-to-back 8N1-style UART frames
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Enable,
  input  logic                 i_Empty,
  input  logic [DATA_BITS-1:0] i_RdData,
  output logic                 o_RdEn,
  output logic                 o_Tx,
  output logic                 o_Busy,
  output logic                 o_Done
);

  uartState_t           r_State, n_State;
  logic [DATA_BITS-1:0] r_Shift, n_Shift;
  logic [2:0]           r_Idx, n_Idx;
  logic                 n_Tx, n_RdEn, n_Busy, n_Done;
  logic                 w_Clear, w_BitEnd, w_BitNear, w_Ld;

  assign w_Ld = i_Enable && !i_Empty;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Clear  (w_Clear),
    .o_BitEnd (w_BitEnd),
    .o_BitNear(w_BitNear)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State <= IDLE;
      r_Shift <= '0;
      r_Idx   <= '0;
      o_Tx    <= 1'b1;
      o_RdEn  <= 1'b0;
      o_Busy  <= 1'b0;
      o_Done  <= 1'b0;
    end else begin
      r_State <= n_State;
      r_Shift <= n_Shift;
      r_Idx   <= n_Idx;
      o_Tx    <= n_Tx;
      o_RdEn  <= n_RdEn;
      o_Busy  <= n_Busy;
      o_Done  <= n_Done;
    end
  end

  always_comb begin
    n_State = r_State;
    n_Shift = r_Shift;
    n_Idx   = r_Idx;
    n_Tx    = o_Tx;
    n_RdEn  = 1'b0;
    n_Busy  = o_Busy;
    n_Done  = 1'b0;
    w_Clear = 1'b0;
    unique case (r_State)
      IDLE: begin
        w_Clear = 1'b1;
        n_Tx    = 1'b1;
        n_Busy  = 1'b0;
        if (w_Ld) begin
          n_State = START;
          n_Shift = i_RdData;
          n_RdEn  = 1'b1;
          n_Tx    = 1'b0;
          n_Busy  = 1'b1;
          n_Idx   = '0;
        end
      end
      START: begin
        if (w_BitEnd) begin
          n_State = DATA;
          n_Tx    = r_Shift[0];
          n_Idx   = '0;
        end
      end
      DATA: begin
        if (w_BitEnd) begin
          if (r_Idx == 3'(DATA_BITS - 1)) begin
            n_State = STOP;
            n_Tx    = 1'b1;
            n_Idx   = '0;
          end else begin
            n_Shift = r_Shift >> 1;
            n_Tx    = r_Shift[1];
            n_Idx   = r_Idx + 3'd1;
          end
        end
      end
      STOP: begin
        // Done is registered, so raise it one cycle ahead of the final stop cycle.
        if ((r_Idx == 3'(STOP_BITS - 1)) && w_BitNear) begin
          n_Done = 1'b1;
        end
        if (w_BitEnd) begin
          if (r_Idx == 3'(STOP_BITS - 1)) begin
            if (w_Ld) begin
              n_State = START;
              n_Shift = i_RdData;
              n_RdEn  = 1'b1;
              n_Tx    = 1'b0;
              n_Idx   = '0;
              w_Clear = 1'b1;
            end else begin
              n_State = IDLE;
              n_Busy  = 1'b0;
            end
          end else begin
            n_Idx = r_Idx + 3'd1;
          end
        end
      end
      default: n_State = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx with a queue-based FIFO
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int DB    = 8;
  localparam int SB    = 1;
  localparam int FRAME = CPB * (1 + DB + SB);

  logic          r_Clk    = 1'b0;
  logic          i_Rst    = 1'b1;
  logic          i_Enable = 1'b0;
  logic          i_Empty  = 1'b1;
  logic [DB-1:0] i_RdData = '0;
  logic          o_RdEn, o_Tx, o_Busy, o_Done;

  always #5 r_Clk = ~r_Clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB)) dut (
    .i_Clk   (r_Clk),
    .i_Rst   (i_Rst),
    .i_Enable(i_Enable),
    .i_Empty (i_Empty),
    .i_RdData(i_RdData),
    .o_RdEn  (o_RdEn),
    .o_Tx    (o_Tx),
    .o_Busy  (o_Busy),
    .o_Done  (o_Done)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // line bits in send order, bit 0 first
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] fifoQ[$];
  logic       txLog[$], rdLog[$], busyLog[$], doneLog[$];
  logic       expQ[$];
  int         passCnt  = 0;
  int         totalCnt = 0;

  task automatic check(input string name, input int act, input int req);
    totalCnt++;
    if (act == req) passCnt++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic refresh();
    i_Empty  = (fifoQ.size() == 0);
    i_RdData = i_Empty ? '0 : fifoQ[0];
  endtask

  task automatic pushByte(input logic [7:0] b);
    fifoQ.push_back(b);
    refresh();
  endtask

  // One clock: sample outputs mid-cycle, pop the FIFO model if a pop was strobed.
  task automatic tick();
    @(negedge r_Clk);
    txLog.push_back(o_Tx);
    rdLog.push_back(o_RdEn);
    busyLog.push_back(o_Busy);
    doneLog.push_back(o_Done);
    if (o_RdEn && fifoQ.size() > 0) fifoQ.delete(0);
    refresh();
  endtask

  task automatic clearLogs();
    txLog.delete();
    rdLog.delete();
    busyLog.delete();
    doneLog.delete();
    expQ.delete();
  endtask

  // Reference frame: start low, data LSB first, stop bits high, each bit CPB samples.
  task automatic appendFrame(input logic [7:0] b);
    for (int bitPos = 0; bitPos < 1 + DB + SB; bitPos++) begin
      logic v;
      if (bitPos == 0) v = 1'b0;
      else if (bitPos <= DB) v = b[bitPos-1];
      else v = 1'b1;
      repeat (CPB) expQ.push_back(v);
    end
  endtask

  function automatic int txMismatch();
    int m = 0;
    for (int i = 0; i < expQ.size(); i++)
      if (i >= txLog.size() || txLog[i] !== expQ[i]) m++;
    return m;
  endfunction

  function automatic int countHigh(input int which, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i < hi; i++) begin
      logic v;
      case (which)
        0: v = (i < txLog.size()) ? txLog[i] : 1'bx;
        1: v = (i < rdLog.size()) ? rdLog[i] : 1'bx;
        2: v = (i < busyLog.size()) ? busyLog[i] : 1'bx;
        default: v = (i < doneLog.size()) ? doneLog[i] : 1'bx;
      endcase
      if (v === 1'b1) c++;
    end
    return c;
  endfunction

  function automatic int nthRd(input int n);
    int seen = 0;
    for (int i = 0; i < rdLog.size(); i++)
      if (rdLog[i] === 1'b1) begin
        if (seen == n) return i;
        seen++;
      end
    return -1;
  endfunction

  function automatic int firstDone();
    for (int i = 0; i < doneLog.size(); i++)
      if (doneLog[i] === 1'b1) return i;
    return -1;
  endfunction

  initial begin
    vecs[0] = '{data: 8'hA5, frame: 10'h34A};
    vecs[1] = '{data: 8'h00, frame: 10'h200};
    vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
    vecs[3] = '{data: 8'h81, frame: 10'h302};

    repeat (3) tick();
    check("reset_tx", int'(o_Tx), 1);
    check("reset_rden", int'(o_RdEn), 0);
    check("reset_busy", int'(o_Busy), 0);
    check("reset_done", int'(o_Done), 0);
    i_Rst = 1'b0;
    i_Enable = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 4; v++) begin
      clearLogs();
      for (int i = 0; i < FRAME; i++) expQ.push_back(vecs[v].frame[i/CPB]);
      pushByte(vecs[v].data);
      repeat (FRAME + 5) tick();
      check($sformatf("vec%0d_frame_bits", v), txMismatch(), 0);
      check($sformatf("vec%0d_rd_pulses", v), countHigh(1, 0, FRAME + 5), 1);
      check($sformatf("vec%0d_done_index", v), firstDone(), FRAME - 1);
      check($sformatf("vec%0d_done_count", v), countHigh(3, 0, FRAME + 5), 1);
      check($sformatf("vec%0d_empty_after", v), int'(i_Empty), 1);
      check($sformatf("vec%0d_busy_after", v), countHigh(2, FRAME, FRAME + 5), 0);
      check($sformatf("vec%0d_idle_high", v), countHigh(0, FRAME, FRAME + 5), 5);
    end

    clearLogs();
    appendFrame(8'h00); appendFrame(8'hFF); appendFrame(8'h3C);
    pushByte(8'h00); pushByte(8'hFF); pushByte(8'h3C);
    repeat (3 * FRAME + 5) tick();
    check("b2b_stream", txMismatch(), 0);
    check("b2b_rd_count", countHigh(1, 0, 3 * FRAME + 5), 3);
    check("b2b_rd_gap1", nthRd(1) - nthRd(0), FRAME);
    check("b2b_rd_gap2", nthRd(2) - nthRd(1), FRAME);
    check("b2b_busy_held", countHigh(2, 0, 3 * FRAME), 3 * FRAME);
    check("b2b_done_count", countHigh(3, 0, 3 * FRAME + 5), 3);
    check("b2b_busy_end", countHigh(2, 3 * FRAME, 3 * FRAME + 5), 0);

    clearLogs();
    repeat (100) tick();
    check("empty_tx_high", countHigh(0, 0, 100), 100);
    check("empty_no_pop", countHigh(1, 0, 100), 0);

    clearLogs();
    appendFrame(8'hA5);
    pushByte(8'hA5); pushByte(8'h3C);
    repeat (20) tick();
    i_Enable = 1'b0;
    repeat (FRAME - 20 + 10) tick();
    check("endrop_frame", txMismatch(), 0);
    check("endrop_rd_count", countHigh(1, 0, FRAME + 10), 1);
    check("endrop_not_empty", int'(i_Empty), 0);
    check("endrop_busy", int'(o_Busy), 0);
    check("endrop_line_high", countHigh(0, FRAME, FRAME + 10), 10);
    fifoQ.delete();
    refresh();
    i_Enable = 1'b1;
    repeat (2) tick();

    clearLogs();
    pushByte(8'h55); pushByte(8'h81);
    repeat (10) tick();
    #2 i_Rst = 1'b1;
    #1;
    check("midrst_tx", int'(o_Tx), 1);
    check("midrst_busy", int'(o_Busy), 0);
    check("midrst_rden", int'(o_RdEn), 0);
    clearLogs();
    repeat (3) tick();
    check("midrst_no_pop", countHigh(1, 0, 3), 0);
    i_Rst = 1'b0;
    clearLogs();
    appendFrame(8'h81);
    repeat (FRAME + 5) tick();
    check("midrst_next_frame", txMismatch(), 0);
    check("midrst_rd_count", countHigh(1, 0, FRAME + 5), 1);
    check("midrst_empty", int'(i_Empty), 1);

    for (int burst = 0; burst < 6; burst++) begin
      int k;
      k = $urandom_range(1, 4);
      clearLogs();
      for (int j = 0; j < k; j++) begin
        logic [7:0] b;
        b = 8'($urandom);
        appendFrame(b);
        fifoQ.push_back(b);
      end
      refresh();
      repeat (k * FRAME + 5) tick();
      check($sformatf("rnd%0d_stream", burst), txMismatch(), 0);
      check($sformatf("rnd%0d_rd_count", burst), countHigh(1, 0, k * FRAME + 5), k);
      check($sformatf("rnd%0d_done_count", burst), countHigh(3, 0, k * FRAME + 5), k);
      repeat ($urandom_range(0, 7)) tick();
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
